// File: rtl/distance_meter_pkg.sv
// Shared sizing for the distance meter and blocks that read its BCD digits.
package distance_meter_pkg;
    localparam int MAX_DISTANCE_UNITS = 3;
endpackage

// File: rtl/run_controller_pkg.sv
// Run controller types, default speeds and BCD distance bundle.
package run_controller_pkg;
    import distance_meter_pkg::*;

    localparam int DIGITS = MAX_DISTANCE_UNITS;

    localparam int DEF_INIT_SPEED    = 6;
    localparam int DEF_MAX_SPEED     = 13;
    localparam int DEF_ACCEL_FRAMES  = 600;
    localparam int DEF_RESTART_DELAY = 30;

    typedef logic [DIGITS-1:0][3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        CRASHED
    } run_state_e;
endpackage

// File: rtl/run_controller_bcd_greater.sv
// Combinational BCD magnitude compare: gt = (a > b), most significant digit first.
module bcd_greater
    import run_controller_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    output logic gt
);

    logic w_decided;

    always_comb begin
        gt        = 1'b0;
        w_decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!w_decided && (a[i] != b[i])) begin
                gt        = (a[i] > b[i]);
                w_decided = 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_controller.sv
// Game run sequencer: start, speed ramp, crash and restart around distance_meter.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int INIT_SPEED    = DEF_INIT_SPEED,
    parameter int MAX_SPEED     = DEF_MAX_SPEED,
    parameter int ACCEL_FRAMES  = DEF_ACCEL_FRAMES,
    parameter int RESTART_DELAY = DEF_RESTART_DELAY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_pulse,
    input  logic       start_btn,
    input  logic       crash,
    input  bcd_t       digits,
    output logic [3:0] speed,
    output logic       meter_clr,
    output run_state_e state,
    output bcd_t       high_score,
    output logic       new_high
);

    localparam int CNT_MAX =
        (ACCEL_FRAMES > RESTART_DELAY) ? ACCEL_FRAMES : RESTART_DELAY;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ACC_LAST = CW'(ACCEL_FRAMES - 1);
    localparam logic [CW-1:0] RD_CNT   = CW'(RESTART_DELAY);
    localparam logic [3:0]    INIT_SPD = 4'(INIT_SPEED);
    localparam logic [3:0]    MAX_SPD  = 4'(MAX_SPEED);

    run_state_e    r_state, w_nxt_state;
    logic [3:0]    r_speed, w_nxt_speed;
    logic          r_clr, w_nxt_clr;
    logic [CW-1:0] r_accel, w_nxt_accel;
    logic [CW-1:0] r_delay, w_nxt_delay;
    bcd_t          r_high, w_nxt_high;
    logic          r_new_high, w_nxt_new_high;
    logic          r_cmp, w_nxt_cmp;
    logic          r_start_q;

    logic w_start_edge;
    logic w_launch;
    logic w_gt;

    assign w_start_edge = start_btn & ~r_start_q;

    // Crash has priority over any start edge while running.
    assign w_launch = w_start_edge &&
        ((r_state == IDLE) ||
         ((r_state == CRASHED) && (r_delay == RD_CNT)));

    bcd_greater u_gt (
        .a  (digits),
        .b  (r_high),
        .gt (w_gt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_speed    <= '0;
            r_clr      <= 1'b0;
            r_accel    <= '0;
            r_delay    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_cmp      <= 1'b0;
            r_start_q  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_speed    <= w_nxt_speed;
            r_clr      <= w_nxt_clr;
            r_accel    <= w_nxt_accel;
            r_delay    <= w_nxt_delay;
            r_high     <= w_nxt_high;
            r_new_high <= w_nxt_new_high;
            r_cmp      <= w_nxt_cmp;
            r_start_q  <= start_btn;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_speed    = r_speed;
        w_nxt_clr      = 1'b0;
        w_nxt_accel    = r_accel;
        w_nxt_delay    = r_delay;
        w_nxt_high     = r_high;
        w_nxt_new_high = r_new_high;
        w_nxt_cmp      = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_nxt_speed = '0;
            end
            RUNNING: begin
                if (crash) begin
                    w_nxt_state = CRASHED;
                    w_nxt_speed = '0;
                    w_nxt_delay = '0;
                    w_nxt_cmp   = 1'b1;
                end else if (timer_pulse) begin
                    if (r_accel == ACC_LAST) begin
                        w_nxt_accel = '0;
                        w_nxt_speed = (r_speed >= MAX_SPD) ?
                            MAX_SPD : r_speed + 4'd1;
                    end else begin
                        w_nxt_accel = r_accel + 1'b1;
                    end
                end
            end
            CRASHED: begin
                // Meter is frozen here, so the digits are the final distance.
                if (r_cmp && w_gt) begin
                    w_nxt_high     = digits;
                    w_nxt_new_high = 1'b1;
                end
                if (timer_pulse && (r_delay != RD_CNT)) begin
                    w_nxt_delay = r_delay + 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_speed = '0;
            end
        endcase

        if (w_launch) begin
            w_nxt_state    = RUNNING;
            w_nxt_clr      = 1'b1;
            w_nxt_speed    = INIT_SPD;
            w_nxt_accel    = '0;
            w_nxt_new_high = 1'b0;
        end
    end

    assign speed      = r_speed;
    assign meter_clr  = r_clr;
    assign state      = r_state;
    assign high_score = r_high;
    assign new_high   = r_new_high;

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller.
module tb_run_controller;
    import run_controller_pkg::*;

    logic       clk;
    logic       rst;
    logic       timer_pulse;
    logic       start_btn;
    logic       crash;
    bcd_t       digits;
    logic [3:0] speed;
    logic       meter_clr;
    run_state_e state;
    bcd_t       high_score;
    logic       new_high;

    int checks = 0;
    int errors = 0;

    run_controller #(
        .INIT_SPEED    (6),
        .MAX_SPEED     (8),
        .ACCEL_FRAMES  (4),
        .RESTART_DELAY (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timer_pulse (timer_pulse),
        .start_btn   (start_btn),
        .crash       (crash),
        .digits      (digits),
        .speed       (speed),
        .meter_clr   (meter_clr),
        .state       (state),
        .high_score  (high_score),
        .new_high    (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        tick(9);
        timer_pulse = 1'b1;
        tick(1);
        timer_pulse = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch();
        start_btn = 1'b1;
        tick(1);
        start_btn = 1'b0;
    endtask

    int clr_cnt;
    int exp_spd;

    initial begin
        rst         = 1'b0;
        timer_pulse = 1'b0;
        start_btn   = 1'b0;
        crash       = 1'b0;
        digits      = '0;
        tick(2);
        chk("rst_state", state, IDLE);
        chk("rst_speed", speed, 0);
        chk("rst_clr", meter_clr, 0);
        chk("rst_high", high_score, 0);
        chk("rst_newhigh", new_high, 0);
        rst = 1'b1;
        tick(1);
        chk("idle_speed", speed, 0);

        // start with held button
        start_btn = 1'b1;
        tick(1);
        chk("t1_state", state, RUNNING);
        chk("t1_speed", speed, 6);
        chk("t1_clr", meter_clr, 1);
        clr_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (meter_clr) clr_cnt++;
        end
        chk("t1_held_clr", clr_cnt, 0);
        start_btn = 1'b0;
        tick(1);

        // speed ramp with saturation
        for (int f = 1; f <= 12; f++) begin
            frame();
            exp_spd = 6 + f / 4;
            if (exp_spd > 8) exp_spd = 8;
            chk($sformatf("t2_speed_f%0d", f), speed, exp_spd);
        end
        chk("t2_clr", meter_clr, 0);

        // first crash sets high score
        digits = 12'h120;
        crash  = 1'b1;
        tick(1);
        crash = 1'b0;
        chk("t3_state", state, CRASHED);
        chk("t3_speed", speed, 0);
        tick(1);
        chk("t3_high", high_score, 12'h120);
        chk("t3_newhigh", new_high, 1);

        // restart gating
        frame();
        frame();
        launch();
        chk("t4_early_state", state, CRASHED);
        chk("t4_early_clr", meter_clr, 0);
        tick(1);
        frame();
        launch();
        chk("t4_state", state, RUNNING);
        chk("t4_clr", meter_clr, 1);
        chk("t4_speed", speed, 6);
        chk("t4_newhigh", new_high, 0);
        tick(1);
        chk("t4_clr_off", meter_clr, 0);

        // equal distance does not update
        crash = 1'b1;
        tick(1);
        crash = 1'b0;
        tick(1);
        chk("t3b_state", state, CRASHED);
        chk("t3b_high", high_score, 12'h120);
        chk("t3b_newhigh", new_high, 0);

        // crash + pulse + start at counter 3
        frame();
        frame();
        frame();
        launch();
        chk("t5_run", state, RUNNING);
        frame();
        frame();
        frame();
        chk("t5_speed_pre", speed, 6);
        digits = 12'h209;
        tick(9);
        crash       = 1'b1;
        timer_pulse = 1'b1;
        start_btn   = 1'b1;
        tick(1);
        crash       = 1'b0;
        timer_pulse = 1'b0;
        start_btn   = 1'b0;
        chk("t5_state", state, CRASHED);
        chk("t5_speed", speed, 0);
        chk("t5_clr", meter_clr, 0);
        tick(1);
        chk("t5_high", high_score, 12'h209);
        chk("t5_newhigh", new_high, 1);
        chk("t5_clr_off", meter_clr, 0);

        // async reset mid-run
        frame();
        frame();
        frame();
        launch();
        tick(2);
        chk("t6_pre_state", state, RUNNING);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_state", state, IDLE);
        chk("t6_speed", speed, 0);
        chk("t6_high", high_score, 0);
        chk("t6_newhigh", new_high, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("t6_after", state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
